memory_64: RTL

- SEQ/PIPE memory stage of the Y86-64 datapath, directly upstream of the writeback stage.
- Holds the byte-addressed data memory and performs the rmmovq/mrmovq/pushq/popq/call/ret accesses.
- Computes the stage status and registers the results (icode, valE, valM, dstE, dstM, stat) into the M/W boundary that writeback consumes.
- Supports stall and bubble control from the hazard unit, plus a sticky halt once a non-AOK status commits.

---
 rtl/memory_64.sv | 115 +++++++++++
 1 files changed

// File: rtl/memory_64.sv
// Y86-64 memory stage: byte-addressed data memory, stage status and the M/W pipeline register.
// Optional macro MEM_ALIGN_CHECK_EN makes unaligned 8-byte accesses raise an ADR error.
module memory_64 #(
  parameter int    MEM_BYTES = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  m_icode,
  input  logic [3:0]  m_stat,
  input  logic [63:0] m_valE,
  input  logic [63:0] m_valA,
  input  logic [63:0] m_valP,
  input  logic [3:0]  m_dstE,
  input  logic [3:0]  m_dstM,
  input  logic        stall,
  input  logic        bubble,
  output logic [63:0] m_valM,
  output logic [3:0]  m_stat_out,
  output logic [3:0]  w_icode,
  output logic [63:0] w_valE,
  output logic [63:0] w_valM,
  output logic [3:0]  w_dstE,
  output logic [3:0]  w_dstM,
  output logic [3:0]  w_stat,
  output logic        halted
);

  localparam int          AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] S_AOK    = 4'h1;
  localparam logic [3:0] S_ADR    = 4'h3;
  localparam logic [3:0] R_NONE   = 4'hF;

  logic [7:0]    mem [MEM_BYTES];
  logic          is_rd, is_wr, dmem_error, wr_en;
  logic [63:0]   addr, wdata, rdata;
  logic [AW-1:0] base;

  // Memory image: zero-filled at time 0. Reset never touches it.
  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
  end

  always_comb begin
    is_rd = (m_icode == I_MRMOVQ) || (m_icode == I_RET) || (m_icode == I_POPQ);
    is_wr = (m_icode == I_RMMOVQ) || (m_icode == I_CALL) || (m_icode == I_PUSHQ);
    addr  = ((m_icode == I_RET) || (m_icode == I_POPQ)) ? m_valA : m_valE;
    wdata = (m_icode == I_CALL) ? m_valP : m_valA;
`ifdef MEM_ALIGN_CHECK_EN
    dmem_error = (is_rd || is_wr) && ((addr > LAST_ADDR) || (addr[2:0] != 3'b000));
`else
    dmem_error = (is_rd || is_wr) && (addr > LAST_ADDR);
`endif
    base = addr[AW-1:0];
  end

  // Little-endian 8-byte read straight from the array; only meaningful when in range.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) rdata[8*i +: 8] = mem[base + AW'(i)];
  end

  assign m_valM     = (is_rd && !dmem_error) ? rdata : 64'd0;
  assign m_stat_out = dmem_error ? S_ADR : m_stat;

  // rst_n gates the enable so a write pending when reset hits is dropped.
  assign wr_en = is_wr && !dmem_error && !stall && !bubble && !halted &&
                 (m_stat == S_AOK) && rst_n;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) mem[base + AW'(i)] <= wdata[8*i +: 8];
    end
  end

  // M/W register: stall beats bubble, bubble beats the halt freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_icode <= I_NOP;
      w_valE  <= '0;
      w_valM  <= '0;
      w_dstE  <= R_NONE;
      w_dstM  <= R_NONE;
      w_stat  <= S_AOK;
      halted  <= 1'b0;
    end else if (stall) begin
      w_icode <= w_icode;
    end else if (bubble) begin
      w_icode <= I_NOP;
      w_valE  <= '0;
      w_valM  <= '0;
      w_dstE  <= R_NONE;
      w_dstM  <= R_NONE;
      w_stat  <= S_AOK;
    end else if (!halted) begin
      w_icode <= m_icode;
      w_valE  <= m_valE;
      w_valM  <= m_valM;
      w_dstE  <= m_dstE;
      w_dstM  <= m_dstM;
      w_stat  <= m_stat_out;
      halted  <= (m_stat_out != S_AOK);
    end
  end

endmodule
